// File: rtl/serial_byte_deframer.sv
// Serial byte deframer: start bit, DATA_W data bits LSB first,
// optional even parity, stop bit; one-deep holding register.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   d                       serial line (idles high), one bit per clk
//   out_data/out_valid      received byte and its valid flag
//   out_ready               consumer accepts when out_valid & out_ready
//   frame_err/parity_err    one-cycle pulses on a bad stop/parity bit
//   overrun                 one-cycle pulse when a good byte is dropped
module serial_byte_deframer #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned PARITY_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_err,
   output logic              parity_err,
   output logic              overrun
);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [4:0] LAST = 5'(DATA_W - 1);

   state_t            state_q;
   logic [4:0]        cnt_q;
   logic [DATA_W-1:0] sh_q;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              ferr_q;
   logic              perr_q;
   logic              ovr_q;
   logic              pmis_q;

   logic              hshk_d;
   logic              good_d;
   logic              load_d;

   assign hshk_d = valid_q & out_ready;
   assign good_d = (state_q == STOP) & d & ~pmis_q;
   // A full register only takes the new byte if it empties on this edge.
   assign load_d = good_d & (~valid_q | out_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         pmis_q  <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         perr_q <= 1'b0;
         ovr_q  <= 1'b0;

         if (load_d) begin
            data_q  <= sh_q;
            valid_q <= 1'b1;
         end else if (hshk_d) begin
            valid_q <= 1'b0;
         end

         if (good_d && !load_d) begin
            ovr_q <= 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (!d) begin
                  state_q <= DATA;
                  cnt_q   <= '0;
                  sh_q    <= '0;
                  pmis_q  <= 1'b0;
               end
            end
            DATA: begin
               // LSB arrives first, so shift toward bit 0.
               sh_q  <= {d, sh_q[DATA_W-1:1]};
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == LAST) begin
                  state_q <= (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
            PARITY: begin
               pmis_q  <= d ^ (^sh_q);
               state_q <= STOP;
            end
            STOP: begin
               // The stop sample never doubles as a start bit.
               ferr_q  <= ~d;
               perr_q  <= pmis_q;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_data   = data_q;
   assign out_valid  = valid_q;
   assign frame_err  = ferr_q;
   assign parity_err = perr_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_byte_deframer.sv
// Directed bench for serial_byte_deframer (DATA_W=8, even parity).
// Frames are driven bit by bit; outputs checked #1 after each edge.
module tb_serial_byte_deframer;

   logic       clk;
   logic       reset;
   logic       d;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;

   int errs;
   int checks;

   int n_val;
   int n_fer;
   int n_per;
   int n_ovr;

   int s_val;
   int s_fer;
   int s_per;
   int s_ovr;

   serial_byte_deframer #(
      .DATA_W(8),
      .PARITY_EN(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .d(d),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .frame_err(frame_err),
      .parity_err(parity_err),
      .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      n_val = 0;
      n_fer = 0;
      n_per = 0;
      n_ovr = 0;
   end

   always @(negedge clk) begin
      if (out_valid)  n_val = n_val + 1;
      if (frame_err)  n_fer = n_fer + 1;
      if (parity_err) n_per = n_per + 1;
      if (overrun)    n_ovr = n_ovr + 1;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errs = errs + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      s_val = n_val;
      s_fer = n_fer;
      s_per = n_per;
      s_ovr = n_ovr;
   endtask

   // start bit, 8 data bits LSB first, parity bit
   task automatic send_body(input logic [7:0] b, input logic p);
      d = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         d = b[i];
         tick();
      end
      d = p;
      tick();
   endtask

   task automatic send_stop(input logic s);
      d = s;
      tick();
      d = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b,
                             input logic p,
                             input logic s);
      send_body(b, p);
      send_stop(s);
   endtask

   initial begin
      errs      = 0;
      checks    = 0;
      reset     = 1'b1;
      d         = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'h00);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_perr", 32'(parity_err), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      reset = 1'b0;
      tick();

      // good frame 0xA5, parity 0
      snap();
      send_frame(8'hA5, 1'b0, 1'b1);
      chk("good_valid", 32'(out_valid), 32'd1);
      chk("good_data", 32'(out_data), 32'hA5);
      chk("good_ferr", 32'(frame_err), 32'd0);
      chk("good_perr", 32'(parity_err), 32'd0);
      chk("good_early", 32'(n_val - s_val), 32'd0);
      tick();
      chk("good_drop", 32'(out_valid), 32'd0);
      chk("good_vcyc", 32'(n_val - s_val), 32'd1);

      // parity error
      snap();
      send_frame(8'hA5, 1'b1, 1'b1);
      chk("par_perr", 32'(parity_err), 32'd1);
      chk("par_ferr", 32'(frame_err), 32'd0);
      chk("par_valid", 32'(out_valid), 32'd0);
      tick();
      chk("par_pulse", 32'(parity_err), 32'd0);
      chk("par_npulse", 32'(n_per - s_per), 32'd1);

      // framing error, then idle line
      snap();
      send_frame(8'hA5, 1'b0, 1'b0);
      chk("frm_ferr", 32'(frame_err), 32'd1);
      chk("frm_perr", 32'(parity_err), 32'd0);
      chk("frm_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 12; i++) tick();
      chk("frm_nfer", 32'(n_fer - s_fer), 32'd1);
      chk("frm_noval", 32'(n_val - s_val), 32'd0);

      // both errors on one frame
      send_frame(8'hA5, 1'b1, 1'b0);
      chk("both_ferr", 32'(frame_err), 32'd1);
      chk("both_perr", 32'(parity_err), 32'd1);
      chk("both_valid", 32'(out_valid), 32'd0);
      tick();

      // back-pressure: 0x3C then 0x81 back-to-back
      out_ready = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b1);
      chk("bp_valid1", 32'(out_valid), 32'd1);
      chk("bp_data1", 32'(out_data), 32'h3C);
      send_frame(8'h81, 1'b0, 1'b1);
      chk("bp_ovr", 32'(overrun), 32'd1);
      chk("bp_data2", 32'(out_data), 32'h3C);
      chk("bp_valid2", 32'(out_valid), 32'd1);
      tick();
      chk("bp_ovr_pls", 32'(overrun), 32'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_drop", 32'(out_valid), 32'd0);
      chk("bp_keep", 32'(out_data), 32'h3C);

      // handshake and load on the same edge
      out_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1);
      chk("hl_valid1", 32'(out_valid), 32'd1);
      send_body(8'h07, 1'b1);
      out_ready = 1'b1;
      send_stop(1'b1);
      chk("hl_data", 32'(out_data), 32'h07);
      chk("hl_valid", 32'(out_valid), 32'd1);
      chk("hl_ovr", 32'(overrun), 32'd0);
      tick();
      chk("hl_drop", 32'(out_valid), 32'd0);

      // reset after 4 data bits, then a full 0x5A frame
      snap();
      d = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         d = i[0];
         tick();
      end
      reset = 1'b1;
      d     = 1'b1;
      tick();
      reset = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b1);
      chk("rmf_data", 32'(out_data), 32'h5A);
      chk("rmf_valid", 32'(out_valid), 32'd1);
      chk("rmf_errs", 32'(n_fer - s_fer + n_per - s_per + n_ovr - s_ovr),
          32'd0);
      chk("rmf_noval", 32'(n_val - s_val), 32'd0);
      tick();

      // reset wins over a good stop bit
      send_body(8'h77, 1'b0);
      reset = 1'b1;
      send_stop(1'b1);
      reset = 1'b0;
      chk("rpri_valid", 32'(out_valid), 32'd0);
      chk("rpri_data", 32'(out_data), 32'h00);

      // idle line
      snap();
      d = 1'b1;
      for (int i = 0; i < 50; i++) tick();
      chk("idle_val", 32'(n_val - s_val), 32'd0);
      chk("idle_fer", 32'(n_fer - s_fer), 32'd0);
      chk("idle_per", 32'(n_per - s_per), 32'd0);
      chk("idle_ovr", 32'(n_ovr - s_ovr), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/serial_byte_deframer.md
SERIAL_BYTE_DEFRAMER -- requirements
Module: serial_byte_deframer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame (legal range 2..16).
REQ-002 SHALL have parameter PARITY_EN, default 1, which inserts an even-parity bit between the data and stop bits when set to 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port d, input, 1 bit: the registered serial bit from the upstream flop, one bit per clk; the line idles at 1.
REQ-006 SHALL have port out_data, output, DATA_W bits: the received byte.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds an unconsumed byte.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data on any cycle where out_valid and out_ready are both 1.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled as 0.
REQ-010 SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good frame is dropped because the holding register is full.

Function
REQ-012 SHALL implement an FSM with states IDLE, DATA, PARITY, STOP, sampling d once per clk in every state.
REQ-013 In IDLE, d=0 SHALL be taken as the start bit: go to DATA, clear the bit counter and the shift register; d=1 SHALL leave the FSM in IDLE.
REQ-014 DATA SHALL shift in exactly DATA_W bits, LSB first, one per clk; after the last bit the FSM SHALL go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-015 PARITY SHALL compare d with the XOR of the DATA_W received bits (even parity), latch a mismatch flag, and go to STOP.
REQ-016 STOP SHALL sample d and return to IDLE in every case.
- d=1 with no parity mismatch: good frame.
- d=0: frame_err pulse on the next cycle; byte discarded.
- d=1 with parity mismatch: parity_err pulse on the next cycle; byte discarded.
REQ-017 If both errors occur in one frame, both frame_err and parity_err SHALL pulse on the same cycle.
REQ-018 For a good frame with out_valid=0, or with out_valid=1 and out_ready=1 on that same STOP cycle, out_data SHALL load the byte and out_valid SHALL be 1 on the next cycle.
REQ-019 Latency SHALL be fixed: out_valid rises exactly 1 clk after the stop-bit sample, i.e. DATA_W+PARITY_EN+2 clks after the start-bit sample.
REQ-020 For a good frame with out_valid=1 and out_ready=0 on the STOP cycle, the block SHALL discard the new byte, keep out_data unchanged, and pulse overrun on the next cycle.
REQ-021 out_valid SHALL fall on the cycle after a handshake unless a new byte loads on the same edge.
REQ-022 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 The block SHALL accept back-to-back frames: a 0 sampled in the cycle right after STOP is a valid start bit.
REQ-024 A 0 sampled as the stop bit SHALL NOT be treated as a start bit.

Reset
REQ-025 While reset=1 at a clk edge, the next state SHALL be: FSM=IDLE, bit counter=0, shift register=0, out_data=0, out_valid=0, frame_err=0, parity_err=0, overrun=0.
REQ-026 A reset in the middle of a frame SHALL abandon the frame with no valid or error pulse; sampling restarts in IDLE on the first cycle after reset is released.
REQ-027 Reset SHALL have priority over every other event in the same cycle, including a handshake.

Verification
REQ-028 Good frame: DATA_W=8, PARITY_EN=1, out_ready=1, d = 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 LSB first, parity 0, stop) -> out_data=0xA5, out_valid high exactly 1 clk, no error pulses.
REQ-029 Parity error: same frame with parity bit 1 -> parity_err pulses 1 clk, out_valid stays 0.
REQ-030 Framing error: same frame with stop bit 0, then d=1 -> frame_err pulses 1 clk, the FSM stays in IDLE, no spurious frame is received.
REQ-031 Back-pressure: out_ready=0, send 0x3C then 0x81 back-to-back -> out_data stays 0x3C, overrun pulses after the second stop bit; raising out_ready then drops out_valid the next cycle.
REQ-032 Reset mid-frame: reset=1 for 1 clk after 4 data bits, then send a full 0x5A frame -> only 0x5A is delivered, with no error pulses.
REQ-033 Idle line: d held at 1 for 50 clks -> out_valid and all error outputs stay 0.
